// File: rtl/display_share_arbiter.sv
// ============================================================================
// Module   : display_share_arbiter
// Purpose  : Round-robin owner selection for one shared 4-bit display path,
//            with a minimum hold time before ownership may rotate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50000000,
    localparam int OW         = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] val,
    output logic [NREQ-1:0]   grant,
    output logic [OW-1:0]     owner,
    output logic [3:0]        disp_val,
    output logic              blank,
    output logic              hold_done
);

    localparam int             CW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  c_cmax = CW'(HOLD_CYCLES - 1);
    localparam logic [NREQ-1:0] c_one = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_last;
    logic [3:0]        r_disp_val;
    logic              r_blank;
    logic              r_hold_done;
    logic [CW-1:0]     r_cnt;

    logic [NREQ-1:0]   w_cand;
    logic [OW-1:0]     w_base;
    logic [OW-1:0]     w_winner;
    logic              w_any;

    // First set bit of r in the order base+1, base+2, ... modulo NREQ.
    function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [OW-1:0]   base);
        logic [OW-1:0] res;
        int            idx;
        res = base;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(base) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (r[idx[OW-1:0]]) res = idx[OW-1:0];
        end
        return res;
    endfunction

    // While owned, only the other requesters compete; the owner is scanned last.
    always_comb begin
        w_cand   = (r_state == ST_IDLE) ? req : (req & ~r_grant);
        w_base   = (r_state == ST_IDLE) ? r_last : r_owner;
        w_any    = |w_cand;
        w_winner = pick(w_cand, w_base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_last      <= OW'(NREQ - 1);
            r_disp_val  <= 4'h0;
            r_blank     <= 1'b1;
            r_hold_done <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_OWNED;
                        r_grant     <= c_one << w_winner;
                        r_owner     <= w_winner;
                        r_disp_val  <= val[{w_winner, 2'b00} +: 4];
                        r_blank     <= 1'b0;
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                ST_OWNED: begin
                    if (r_hold_done && w_any) begin
                        r_last      <= r_owner;
                        r_grant     <= c_one << w_winner;
                        r_owner     <= w_winner;
                        r_disp_val  <= val[{w_winner, 2'b00} +: 4];
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_hold_done && !req[r_owner]) begin
                        r_state     <= ST_IDLE;
                        r_last      <= r_owner;
                        r_grant     <= '0;
                        r_owner     <= '0;
                        r_disp_val  <= 4'h0;
                        r_blank     <= 1'b1;
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_disp_val  <= val[{r_owner, 2'b00} +: 4];
                        r_hold_done <= r_hold_done | (r_cnt == c_cmax);
                        if (r_cnt != c_cmax) r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign owner     = r_owner;
    assign disp_val  = r_disp_val;
    assign blank     = r_blank;
    assign hold_done = r_hold_done;

endmodule

`default_nettype wire

// File: tb/tb_display_share_arbiter.sv
// ============================================================================
// Module   : tb_display_share_arbiter
// Purpose  : Directed and randomized checks of display_share_arbiter against
//            a cycle-level ownership model (owner, age since grant, pointer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_share_arbiter;

    localparam int NREQ = 4;
    localparam int H    = 4;
    localparam int OW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] val;
    logic [NREQ-1:0]   grant;
    logic [OW-1:0]     owner;
    logic [3:0]        disp_val;
    logic              blank;
    logic              hold_done;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit         m_idle;
    int         m_owner;
    int         m_age;
    int         m_last;
    logic [3:0] m_disp;

    display_share_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(H)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .val       (val),
        .grant     (grant),
        .owner     (owner),
        .disp_val  (disp_val),
        .blank     (blank),
        .hold_done (hold_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int scan(input logic [NREQ-1:0] r, input int base);
        for (int i = 1; i <= NREQ; i++) begin
            if (r[(base + i) % NREQ]) return (base + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] val_of(input int i);
        return 4'((val >> (4 * i)) & 16'hF);
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_owner = 0;
        m_age   = 0;
        m_last  = NREQ - 1;
        m_disp  = 4'h0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] others;
        if (m_idle) begin
            if (req != 0) begin
                m_owner = scan(req, m_last);
                m_idle  = 1'b0;
                m_age   = 0;
                m_disp  = val_of(m_owner);
            end
        end else begin
            others = req & ~(NREQ'(1) << m_owner);
            if (m_age >= H && others != 0) begin
                m_last  = m_owner;
                m_owner = scan(others, m_owner);
                m_age   = 0;
                m_disp  = val_of(m_owner);
            end else if (m_age >= H && !req[m_owner]) begin
                m_last  = m_owner;
                m_idle  = 1'b1;
                m_owner = 0;
                m_age   = 0;
                m_disp  = 4'h0;
            end else begin
                m_age++;
                m_disp = val_of(m_owner);
            end
        end
    endtask

    task automatic compare_all();
        check("grant", 32'(grant), m_idle ? 32'd0 : (32'd1 << m_owner));
        check("owner", 32'(owner), 32'(m_owner));
        check("disp_val", 32'(disp_val), 32'(m_disp));
        check("blank", 32'(blank), 32'(m_idle));
        check("hold_done", 32'(hold_done), 32'(!m_idle && m_age >= H));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] seq[$];
        logic [NREQ-1:0] prev;

        rst_n = 1'b0;
        req   = '0;
        val   = '0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, hold, value tracking
        val[3:0] = 4'h7;
        req      = 4'b0001;
        step();
        check("single_grant", 32'(grant), 32'h1);
        check("single_disp", 32'(disp_val), 32'h7);
        for (int i = 0; i < H; i++) step();
        check("single_hold", 32'(hold_done), 32'h1);
        repeat (3) step();
        check("single_stays", 32'(grant), 32'h1);
        val[3:0] = 4'hD;
        step();
        check("track_disp", 32'(disp_val), 32'hD);
        req = '0;
        repeat (2) step();

        // Round-robin rotation from reset
        pulse_reset();
        req  = 4'b1111;
        prev = '0;
        for (int i = 0; i < 5 * (H + 1); i++) begin
            step();
            check("no_gap", 32'(grant == 0), 32'h0);
            if (grant != prev) seq.push_back(grant);
            prev = grant;
        end
        check("rot_len", 32'(seq.size()), 32'd5);
        if (seq.size() == 5) begin
            check("rot0", 32'(seq[0]), 32'h1);
            check("rot1", 32'(seq[1]), 32'h2);
            check("rot2", 32'(seq[2]), 32'h4);
            check("rot3", 32'(seq[3]), 32'h8);
            check("rot4", 32'(seq[4]), 32'h1);
        end

        // Early drop by owner 2
        pulse_reset();
        req = 4'b0100;
        step();
        check("drop_grant", 32'(grant), 32'h4);
        req = '0;
        for (int i = 0; i < H; i++) step();
        check("drop_kept", 32'(grant), 32'h4);
        check("drop_hold", 32'(hold_done), 32'h1);
        step();
        check("drop_idle_grant", 32'(grant), 32'h0);
        check("drop_idle_blank", 32'(blank), 32'h1);

        // Pointer fairness after owner 3 releases
        req = 4'b1000;
        step();
        req = '0;
        repeat (H + 2) step();
        req = 4'b1001;
        step();
        check("fair_grant", 32'(grant), 32'h1);

        // Asynchronous reset mid-hold
        pulse_reset();
        req = 4'b0010;
        step();
        step();
        check("async_pre", 32'(grant), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_grant", 32'(grant), 32'h0);
        check("async_blank", 32'(blank), 32'h1);
        check("async_disp", 32'(disp_val), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        check("async_after", 32'(grant), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            val = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
